uart_cmd_ctrl: RTL and testbench

- Sequences the `uart_rx` receiver and turns its byte stream into register-write commands for the front-end control registers.
- Drains received bytes with the `uld_rx_data` handshake and parses 3-byte frames (header, data, checksum).
- Issues single-cycle write strobes, counts framing/checksum faults, and owns the receiver's `rx_enable` and `baud_rate` configuration.
- Sits between the `uart_rx` instance and the register bank.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_byte_fetch.sv | 34 +++
 rtl/uart_cmd_ctrl.sv | 176 +++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command controller.
package uart_pkg;

    // Frame parser states
    typedef enum logic [1:0] {
        ST_HDR   = 2'd0,
        ST_DAT   = 2'd1,
        ST_CHK   = 2'd2,
        ST_RXOFF = 2'd3
    } state_e;

    // Receiver rate-select codes
    localparam logic [1:0] BAUD_115200 = 2'd0;
    localparam logic [1:0] BAUD_230400 = 2'd1;
    localparam logic [1:0] BAUD_460800 = 2'd2;

    // XOR key folded into every frame checksum
    localparam logic [7:0] CSUM_KEY = 8'h5A;

    // Frame address reserved for baud-rate configuration
    localparam logic [6:0] BAUD_ADDR_DEF = 7'h7F;

    // Map a requested rate code onto a supported one; code 3 falls back to 115200
    function automatic logic [1:0] baud_sanitize(input logic [1:0] code);
        logic [1:0] res;
        case (code)
            BAUD_230400: res = BAUD_230400;
            BAUD_460800: res = BAUD_460800;
            default:     res = BAUD_115200;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uart_byte_fetch.sv
// Unload handshake with uart_rx: captures one byte and holds the unload
// request until the receiver reports empty, so a byte is never read twice.
module uart_byte_fetch
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       flush,
    input  logic [7:0] rx_data,
    input  logic       rx_empty,
    output logic       uld_rx_data,
    output logic       byte_vld_c,
    output logic [7:0] byte_c
);

    // A byte is taken only when none is in flight
    assign byte_vld_c = en && !rx_empty && !uld_rx_data;
    assign byte_c     = rx_data;

    // Unload request: set on capture, held until the receiver drains
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uld_rx_data <= 1'b0;
        end else if (flush) begin
            uld_rx_data <= 1'b0;
        end else if (byte_vld_c) begin
            uld_rx_data <= 1'b1;
        end else if (uld_rx_data && rx_empty) begin
            uld_rx_data <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses 3-byte (header, data, checksum) frames from uart_rx into register
// writes, owns the receiver enable / rate select, and tracks frame faults.
module uart_cmd_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC  = 40000,
    parameter int unsigned RXEN_OFF_CYC = 4,
    parameter logic [6:0]  BAUD_ADDR    = BAUD_ADDR_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_empty,
    output logic       uld_rx_data,
    output logic       rx_enable,
    output logic [1:0] baud_rate,
    output logic       wr_en,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] csum_err_cnt,
    output logic       sync_err,
    output logic       timeout_err
);

    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned OFF_W = $clog2(RXEN_OFF_CYC + 1);

    state_e             state_q, state_d;
    logic [6:0]         addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [OFF_W-1:0]   off_cnt_q, off_cnt_d;
    logic               rx_enable_d;
    logic [1:0]         baud_rate_d;
    logic               wr_en_d;
    logic [6:0]         wr_addr_d;
    logic [7:0]         wr_data_d;
    logic [7:0]         csum_err_cnt_d;
    logic               sync_err_d;
    logic               timeout_err_d;

    logic               fetch_en_c;
    logic               fetch_flush_c;
    logic               byte_vld_c;
    logic [7:0]         byte_c;
    logic [7:0]         exp_chk_c;
    logic               to_hit_c;

    // No fetching while the receiver is being cleared
    assign fetch_en_c    = (state_q != ST_RXOFF);
    assign fetch_flush_c = (state_d == ST_RXOFF);

    uart_byte_fetch u_fetch (
        .clk         (clk),
        .reset       (reset),
        .en          (fetch_en_c),
        .flush       (fetch_flush_c),
        .rx_data     (rx_data),
        .rx_empty    (rx_empty),
        .uld_rx_data (uld_rx_data),
        .byte_vld_c  (byte_vld_c),
        .byte_c      (byte_c)
    );

    assign exp_chk_c = {1'b1, addr_q} ^ data_q ^ CSUM_KEY;
    assign to_hit_c  = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    // Next-state, next-output and counter logic for the frame parser
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        data_d         = data_q;
        to_cnt_d       = '0;
        off_cnt_d      = '0;
        rx_enable_d    = rx_enable;
        baud_rate_d    = baud_rate;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr;
        wr_data_d      = wr_data;
        csum_err_cnt_d = csum_err_cnt;
        sync_err_d     = 1'b0;
        timeout_err_d  = 1'b0;

        case (state_q)
            ST_HDR: begin
                if (byte_vld_c) begin
                    if (!byte_c[7]) begin
                        sync_err_d = 1'b1;
                    end else begin
                        addr_d  = byte_c[6:0];
                        state_d = ST_DAT;
                    end
                end
            end
            ST_DAT: begin
                if (byte_vld_c) begin
                    data_d  = byte_c;
                    state_d = ST_CHK;
                end else if (to_hit_c) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_HDR;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_CHK: begin
                if (byte_vld_c) begin
                    state_d = ST_HDR;
                    if (byte_c != exp_chk_c) begin
                        if (csum_err_cnt != 8'hFF) begin
                            csum_err_cnt_d = csum_err_cnt + 8'd1;
                        end
                    end else if (addr_q == BAUD_ADDR) begin
                        baud_rate_d = baud_sanitize(data_q[1:0]);
                        rx_enable_d = 1'b0;
                        state_d     = ST_RXOFF;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = data_q;
                    end
                end else if (to_hit_c) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_HDR;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_RXOFF: begin
                if (off_cnt_q == OFF_W'(RXEN_OFF_CYC - 1)) begin
                    rx_enable_d = 1'b1;
                    state_d     = ST_HDR;
                end else begin
                    off_cnt_d = off_cnt_q + OFF_W'(1);
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_HDR;
            addr_q       <= '0;
            data_q       <= '0;
            to_cnt_q     <= '0;
            off_cnt_q    <= '0;
            rx_enable    <= 1'b1;
            baud_rate    <= BAUD_115200;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            csum_err_cnt <= '0;
            sync_err     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            to_cnt_q     <= to_cnt_d;
            off_cnt_q    <= off_cnt_d;
            rx_enable    <= rx_enable_d;
            baud_rate    <= baud_rate_d;
            wr_en        <= wr_en_d;
            wr_addr      <= wr_addr_d;
            wr_data      <= wr_data_d;
            csum_err_cnt <= csum_err_cnt_d;
            sync_err     <= sync_err_d;
            timeout_err  <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus pushes expected events,
// a negedge monitor pops and compares whenever the DUT reports one.
module tb_uart_cmd_ctrl;

    localparam int unsigned TO  = 64;
    localparam int unsigned OFF = 4;

    localparam logic [2:0] EV_WR   = 3'd0;
    localparam logic [2:0] EV_CSUM = 3'd1;
    localparam logic [2:0] EV_SYNC = 3'd2;
    localparam logic [2:0] EV_TO   = 3'd3;
    localparam logic [2:0] EV_BAUD = 3'd4;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] a;
        logic [7:0] b;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_empty = 1'b1;
    logic       uld_rx_data;
    logic       rx_enable;
    logic [1:0] baud_rate;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] csum_err_cnt;
    logic       sync_err;
    logic       timeout_err;

    ev_t  exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   m_csum = 0;
    int   uld_rises = 0;
    int   rxen_run = 0;
    int   rxen_last_run = 0;
    logic prev_uld = 1'b0;
    logic [7:0] prev_csum = 8'h00;
    logic [1:0] prev_baud = 2'd0;

    uart_cmd_ctrl #(
        .TIMEOUT_CYC  (TO),
        .RXEN_OFF_CYC (OFF),
        .BAUD_ADDR    (7'h7F)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .uld_rx_data  (uld_rx_data),
        .rx_enable    (rx_enable),
        .baud_rate    (baud_rate),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .csum_err_cnt (csum_err_cnt),
        .sync_err     (sync_err),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    endtask

    task automatic push_ev(input logic [2:0] kind, input logic [7:0] a, input logic [7:0] b);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input string name, input logic [2:0] kind,
                           input logic [7:0] a, input logic [7:0] b);
        ev_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: unexpected event kind=%0d a='h%0h b='h%0h, expected none",
                     name, kind, a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.a == a && e.b == b) n_pass++;
            else $display("FAIL %s: got kind=%0d a='h%0h b='h%0h, expected kind=%0d a='h%0h b='h%0h",
                          name, kind, a, b, e.kind, e.a, e.b);
        end
    endtask

    // Monitor: compares every DUT-reported event against the scoreboard
    always @(negedge clk) begin
        if (uld_rx_data && !prev_uld) uld_rises++;
        prev_uld = uld_rx_data;
        if (!rx_enable) begin
            rxen_run++;
        end else if (rxen_run > 0) begin
            rxen_last_run = rxen_run;
            rxen_run = 0;
        end
        if (!reset) begin
            prev_csum = 8'h00;
            prev_baud = 2'd0;
        end else begin
            if (wr_en)       pop_cmp("wr_event", EV_WR, {1'b0, wr_addr}, wr_data);
            if (sync_err)    pop_cmp("sync_event", EV_SYNC, 8'h00, 8'h00);
            if (timeout_err) pop_cmp("timeout_event", EV_TO, 8'h00, 8'h00);
            if (csum_err_cnt != prev_csum) begin
                pop_cmp("csum_event", EV_CSUM, 8'h00, csum_err_cnt);
                prev_csum = csum_err_cnt;
            end
            if (baud_rate != prev_baud) begin
                pop_cmp("baud_event", EV_BAUD, 8'h00, {6'd0, baud_rate});
                prev_baud = baud_rate;
            end
        end
    end

    // Behaves like uart_rx holding one byte; extra models stop-bit overlap
    task automatic send_byte(input logic [7:0] b, input int extra);
        int k;
        rx_data  = b;
        rx_empty = 1'b0;
        k = 0;
        @(negedge clk);
        while (!uld_rx_data && rx_enable && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) begin
            n_total++;
            $display("FAIL fetch_wait: byte 'h%0h never unloaded, got uld=%0d, expected 1", b, uld_rx_data);
        end
        repeat (extra) @(negedge clk);
        rx_empty = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] d, input logic [7:0] c);
        send_byte(h, 0);
        send_byte(d, 0);
        send_byte(c, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_uld"},   uld_rx_data,  0);
        check({tag, "_rxen"},  rx_enable,    1);
        check({tag, "_baud"},  baud_rate,    0);
        check({tag, "_wren"},  wr_en,        0);
        check({tag, "_waddr"}, wr_addr,      0);
        check({tag, "_wdata"}, wr_data,      0);
        check({tag, "_csum"},  csum_err_cnt, 0);
        check({tag, "_sync"},  sync_err,     0);
        check({tag, "_tout"},  timeout_err,  0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int cyc;
        logic [7:0] d;
        logic [7:0] c;

        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Basic write frame
        r0 = uld_rises;
        push_ev(EV_WR, 8'h05, 8'h3C);
        send_frame(8'h85, 8'h3C, 8'hE3);
        check("uld_pulses_basic", uld_rises - r0, 3);

        // Bad checksum, write bus holds last value
        m_csum = 1;
        push_ev(EV_CSUM, 8'h00, 8'd1);
        send_frame(8'h85, 8'h3C, 8'h00);
        check("waddr_hold", wr_addr, 7'h05);
        check("wdata_hold", wr_data, 8'h3C);

        // Stray non-header byte, then a clean frame
        push_ev(EV_SYNC, 8'h00, 8'h00);
        send_byte(8'h12, 0);
        push_ev(EV_WR, 8'h0A, 8'h77);
        send_frame(8'h8A, 8'h77, 8'hA7);

        // Timeout after a lone header: pulse TO+1 negedges after the byte is driven
        push_ev(EV_TO, 8'h00, 8'h00);
        send_byte(8'h85, 0);
        cyc = 2;
        while (!timeout_err && cyc < int'(TO) + 20) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_latency", cyc, int'(TO) + 1);
        @(negedge clk);
        push_ev(EV_WR, 8'h05, 8'h3C);
        send_frame(8'h85, 8'h3C, 8'hE3);

        // Data byte captured on the terminal count cycle beats the timeout
        push_ev(EV_WR, 8'h05, 8'h3C);
        send_byte(8'h85, 0);
        repeat (TO - 2) @(negedge clk);
        send_byte(8'h3C, 0);
        send_byte(8'hE3, 0);

        // Baud change to 460800
        r0 = uld_rises;
        push_ev(EV_BAUD, 8'h00, 8'd2);
        send_frame(8'hFF, 8'h02, 8'hA7);
        repeat (OFF + 3) @(negedge clk);
        check("uld_pulses_baud", uld_rises - r0, 2);
        check("rxen_low_cycles", rxen_last_run, OFF);
        check("rxen_restored", rx_enable, 1);
        check("baud_460800", baud_rate, 2);
        push_ev(EV_WR, 8'h05, 8'h3C);
        send_frame(8'h85, 8'h3C, 8'hE3);
        check("baud_hold", baud_rate, 2);

        // Rate code 3 falls back to 115200
        push_ev(EV_BAUD, 8'h00, 8'd0);
        send_frame(8'hFF, 8'h03, 8'hA6);
        repeat (OFF + 3) @(negedge clk);
        check("baud_code3", baud_rate, 0);

        // Stop-bit overlap: receiver ignores unload for 3 extra cycles
        r0 = uld_rises;
        push_ev(EV_WR, 8'h05, 8'h3C);
        send_byte(8'h85, 3);
        send_byte(8'h3C, 0);
        send_byte(8'hE3, 0);
        check("uld_pulses_overlap", uld_rises - r0, 3);

        // Checksum error counter saturation
        for (int i = 0; i < 256; i++) begin
            d = 8'(i);
            c = (8'h85 ^ d ^ 8'h5A) ^ 8'hFF;
            if (m_csum != 255) begin
                m_csum++;
                push_ev(EV_CSUM, 8'h00, 8'(m_csum));
            end
            send_frame(8'h85, d, c);
        end
        check("csum_saturated", csum_err_cnt, 255);

        // Reset in the middle of a frame loses it
        send_byte(8'h85, 0);
        send_byte(8'h3C, 0);
        reset = 1'b0;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        // Orphaned checksum byte now reads as a header and times out
        push_ev(EV_TO, 8'h00, 8'h00);
        send_byte(8'hE3, 0);
        repeat (TO + 10) @(negedge clk);
        push_ev(EV_WR, 8'h0A, 8'h77);
        send_frame(8'h8A, 8'h77, 8'hA7);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
